// File: rtl/spi_drive_cmd.sv
// SPI-slave receiver for one-byte wheel drive frames (header 4'hA, L[3:2], R[1:0]).
// Optional command watchdog enabled by defining SPI_DRIVE_CMD_WDT_EN.
module spi_drive_cmd #(
  parameter int unsigned     TW      = 16,
  parameter logic [TW-1:0]   TIMEOUT = 16'd30000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sck,
  input  logic       mosi,
  input  logic       cs_n,
  output logic [1:0] instr_l,
  output logic [1:0] instr_r,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  state_e     state_q;
  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [2:0] mosi_q;
  logic [7:0] shift_q;
  logic [3:0] cnt_q;
  logic [1:0] instr_l_q, instr_r_q;
  logic       frame_ok_q, frame_err_q;

  logic       sck_rise, cs_fall, cs_rise;
  logic       frame_valid;
  logic       wdt_expire;

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c == 4'd9) ? 4'd9 : c + 4'd1;
  endfunction

  function automatic logic [1:0] remap(input logic [1:0] f);
    return (f == 2'b00) ? 2'b11 : f;
  endfunction

  // Sync chains reset to 0 so a cs_n already low at reset release never looks like a fall.
  // cs stage 3 freezes during CHECK so a fall arriving then is still seen back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sck_q <= 3'b000;
      cs_q  <= 3'b000;
    end else begin
      sck_q      <= {sck_q[1:0], sck};
      cs_q[1:0]  <= {cs_q[0], cs_n};
      if (state_q != CHECK) cs_q[2] <= cs_q[1];
    end
  end

  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];

  assign frame_valid = (state_q == CHECK) && (cnt_q == 4'd8) && (shift_q[7:4] == 4'hA);

  // Data path: mosi sync chain and frame shift register carry no reset.
  always_ff @(posedge clk) begin
    mosi_q <= {mosi_q[1:0], mosi};
    if (state_q == IDLE && cs_fall) begin
      shift_q <= 8'h00;
    end else if (state_q == SHIFT && !cs_rise && sck_rise) begin
      shift_q <= {shift_q[6:0], mosi_q[2]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      instr_l_q   <= 2'b11;
      instr_r_q   <= 2'b11;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (wdt_expire) begin
        instr_l_q <= 2'b11;
        instr_r_q <= 2'b11;
      end
      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            cnt_q   <= 4'd0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            state_q <= CHECK;
          end else if (sck_rise) begin
            cnt_q <= sat_inc(cnt_q);
          end
        end
        CHECK: begin
          state_q <= IDLE;
          if (frame_valid) begin
            instr_l_q  <= remap(shift_q[3:2]);
            instr_r_q  <= remap(shift_q[1:0]);
            frame_ok_q <= 1'b1;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SPI_DRIVE_CMD_WDT_EN
  logic [TW-1:0] wdt_q;
  logic          timeout_q;

  // A valid frame on the expiry edge wins: counter reloads and timeout stays low.
  assign wdt_expire = !frame_valid && (wdt_q == TIMEOUT - TW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (frame_valid) begin
      wdt_q     <= '0;
      timeout_q <= 1'b0;
    end else if (wdt_q != TIMEOUT) begin
      wdt_q <= wdt_q + TW'(1);
      if (wdt_expire) timeout_q <= 1'b1;
    end
  end

  assign timeout = timeout_q;
`else
  assign wdt_expire = 1'b0;
  assign timeout    = 1'b0;
`endif

  assign instr_l   = instr_l_q;
  assign instr_r   = instr_r_q;
  assign frame_ok  = frame_ok_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_drive_cmd.sv
// Randomised self-checking bench for spi_drive_cmd with a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_drive_cmd;
  localparam int TMO = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       cs_n = 1'b1;
  logic [1:0] instr_l, instr_r;
  logic       frame_ok, frame_err, timeout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ok_cnt = 0;
  int err_cnt = 0;
  int wdt_base = 0;

  // Reference model state: expected instructions and expected pulse totals.
  logic [1:0] m_l = 2'b11;
  logic [1:0] m_r = 2'b11;
  int         m_ok = 0;
  int         m_err = 0;

  spi_drive_cmd #(.TW(16), .TIMEOUT(16'd100)) dut (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .cs_n(cs_n),
    .instr_l(instr_l), .instr_r(instr_r),
    .frame_ok(frame_ok), .frame_err(frame_err), .timeout(timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    #2;
    if (frame_ok === 1'b1) begin
      ok_cnt++;
      wdt_base = cyc;
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [1:0] remap(input logic [1:0] f);
    return (f == 2'b00) ? 2'b11 : f;
  endfunction

  function automatic logic m_timeout();
`ifdef SPI_DRIVE_CMD_WDT_EN
    return (cyc - wdt_base) >= TMO;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [1:0] exp_l();
    return m_timeout() ? 2'b11 : m_l;
  endfunction

  function automatic logic [1:0] exp_r();
    return m_timeout() ? 2'b11 : m_r;
  endfunction

  task automatic model_frame(input logic [8:0] bits, input int n);
    if (n == 8 && bits[7:4] == 4'hA) begin
      m_l = remap(bits[3:2]);
      m_r = remap(bits[1:0]);
      m_ok++;
    end else begin
      m_err++;
    end
  endtask

  task automatic shift_bits(input logic [8:0] bits, input int n, input int half);
    repeat (half) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      mosi = bits[i];
      repeat (half) @(negedge clk);
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
    end
    repeat (half) @(negedge clk);
  endtask

  task automatic run_frame(input logic [8:0] bits, input int n, input int half);
    cs_n = 1'b0;
    shift_bits(bits, n, half);
    cs_n = 1'b1;
    model_frame(bits, n);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cs_n  = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wdt_base = cyc;
    repeat (2) @(negedge clk);
    tests++; if (instr_l !== 2'b11) begin fails++; $display("FAIL reset_instr_l got %b exp 11", instr_l); end
    tests++; if (instr_r !== 2'b11) begin fails++; $display("FAIL reset_instr_r got %b exp 11", instr_r); end
    tests++; if (frame_ok !== 1'b0) begin fails++; $display("FAIL reset_frame_ok got %b exp 0", frame_ok); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err got %b exp 0", frame_err); end
    tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout got %b exp 0", timeout); end
  endtask

  task automatic test_valid_frame();
    cs_n = 1'b0;
    shift_bits(9'h0A6, 8, 4);
    cs_n = 1'b1;
    model_frame(9'h0A6, 8);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      tests++;
      if (frame_ok !== 1'(i == 4)) begin
        fails++; $display("FAIL valid_latency clk %0d after cs rise: frame_ok %b exp %b", i, frame_ok, 1'(i == 4));
      end
    end
    repeat (2) @(negedge clk);
    tests++; if (instr_l !== 2'b01) begin fails++; $display("FAIL valid_instr_l got %b exp 01", instr_l); end
    tests++; if (instr_r !== 2'b10) begin fails++; $display("FAIL valid_instr_r got %b exp 10", instr_r); end
    tests++; if (ok_cnt !== m_ok || err_cnt !== m_err) begin
      fails++; $display("FAIL valid_pulses ok %0d err %0d exp ok %0d err %0d", ok_cnt, err_cnt, m_ok, m_err);
    end
  endtask

  task automatic test_bad_header();
    run_frame(9'h056, 8, 4);
    tests++; if (err_cnt !== m_err || ok_cnt !== m_ok) begin
      fails++; $display("FAIL bad_header_pulses ok %0d err %0d exp ok %0d err %0d", ok_cnt, err_cnt, m_ok, m_err);
    end
    tests++; if (instr_l !== exp_l() || instr_r !== exp_r()) begin
      fails++; $display("FAIL bad_header_hold got %b/%b exp %b/%b", instr_l, instr_r, exp_l(), exp_r());
    end
  endtask

  task automatic test_bit_count();
    int err0;
    err0 = err_cnt;
    run_frame(9'h0A6 >> 1, 7, 3);
    run_frame(9'h14D, 9, 5);
    tests++; if (err_cnt - err0 !== 2 || ok_cnt !== m_ok) begin
      fails++; $display("FAIL bit_count_errs got %0d err pulses, ok %0d, exp 2 err, ok %0d", err_cnt - err0, ok_cnt, m_ok);
    end
    tests++; if (instr_l !== exp_l() || instr_r !== exp_r()) begin
      fails++; $display("FAIL bit_count_hold got %b/%b exp %b/%b", instr_l, instr_r, exp_l(), exp_r());
    end
  endtask

  task automatic test_zero_field();
    run_frame(9'h0A0, 8, 3);
    tests++; if (instr_l !== 2'b11 || instr_r !== 2'b11) begin
      fails++; $display("FAIL zero_field got %b/%b exp 11/11", instr_l, instr_r);
    end
    tests++; if (ok_cnt !== m_ok) begin fails++; $display("FAIL zero_field_ok got %0d exp %0d", ok_cnt, m_ok); end
  endtask

  task automatic test_watchdog();
    int guard;
    run_frame(9'h0A5, 8, 3);
`ifdef SPI_DRIVE_CMD_WDT_EN
    guard = 0;
    while (cyc < wdt_base + TMO - 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    tests++; if (timeout !== 1'b0 || instr_l !== 2'b01 || instr_r !== 2'b01) begin
      fails++; $display("FAIL wdt_before got to=%b %b/%b exp to=0 01/01", timeout, instr_l, instr_r);
    end
    @(negedge clk);
    tests++; if (timeout !== 1'b1 || instr_l !== 2'b11 || instr_r !== 2'b11) begin
      fails++; $display("FAIL wdt_trip got to=%b %b/%b exp to=1 11/11", timeout, instr_l, instr_r);
    end
    run_frame(9'h0A9, 8, 3);
    tests++; if (timeout !== 1'b0 || instr_l !== 2'b10 || instr_r !== 2'b01) begin
      fails++; $display("FAIL wdt_clear got to=%b %b/%b exp to=0 10/01", timeout, instr_l, instr_r);
    end
`else
    guard = 0;
    repeat (150) @(negedge clk);
    tests++; if (timeout !== 1'b0 || instr_l !== 2'b01 || instr_r !== 2'b01) begin
      fails++; $display("FAIL no_wdt_hold got to=%b %b/%b exp to=0 01/01 (guard %0d)", timeout, instr_l, instr_r, guard);
    end
`endif
  endtask

  task automatic test_reset_mid_frame();
    run_frame(9'h0A6, 8, 3);
    cs_n = 1'b0;
    shift_bits(9'h00A, 4, 3);
    reset = 1'b0;
    #1;
    m_l = 2'b11;
    m_r = 2'b11;
    tests++; if (instr_l !== 2'b11 || instr_r !== 2'b11) begin
      fails++; $display("FAIL reset_async got %b/%b exp 11/11", instr_l, instr_r);
    end
    @(negedge clk);
    reset = 1'b1;
    wdt_base = cyc;
    shift_bits(9'h0A6, 8, 3);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
    tests++; if (ok_cnt !== m_ok || err_cnt !== m_err) begin
      fails++; $display("FAIL cs_low_release_pulses ok %0d err %0d exp ok %0d err %0d", ok_cnt, err_cnt, m_ok, m_err);
    end
    tests++; if (instr_l !== exp_l() || instr_r !== exp_r()) begin
      fails++; $display("FAIL cs_low_release_instr got %b/%b exp %b/%b", instr_l, instr_r, exp_l(), exp_r());
    end
  endtask

  task automatic test_back_to_back();
    cs_n = 1'b0;
    shift_bits(9'h0A9, 8, 3);
    cs_n = 1'b1;
    @(negedge clk);
    cs_n = 1'b0;
    shift_bits(9'h0AE, 8, 3);
    cs_n = 1'b1;
    model_frame(9'h0A9, 8);
    model_frame(9'h0AE, 8);
    repeat (8) @(negedge clk);
    tests++; if (ok_cnt !== m_ok || err_cnt !== m_err) begin
      fails++; $display("FAIL b2b_pulses ok %0d err %0d exp ok %0d err %0d", ok_cnt, err_cnt, m_ok, m_err);
    end
    tests++; if (instr_l !== exp_l() || instr_r !== exp_r()) begin
      fails++; $display("FAIL b2b_instr got %b/%b exp %b/%b", instr_l, instr_r, exp_l(), exp_r());
    end
  endtask

  task automatic test_random();
    logic [8:0] bits;
    int         n, half;
    for (int k = 0; k < 24; k++) begin
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 9)) : 8;
      bits = 9'($urandom);
      if ($urandom_range(0, 1) == 1) bits[7:4] = 4'hA;
      half = $urandom_range(3, 6);
      run_frame(bits, n, half);
      tests++; if (ok_cnt !== m_ok || err_cnt !== m_err) begin
        fails++; $display("FAIL rand%0d_pulses bits %h n %0d: ok %0d err %0d exp ok %0d err %0d", k, bits, n, ok_cnt, err_cnt, m_ok, m_err);
      end
      tests++; if (instr_l !== exp_l() || instr_r !== exp_r() || timeout !== m_timeout()) begin
        fails++; $display("FAIL rand%0d_out bits %h n %0d: %b/%b to=%b exp %b/%b to=%b", k, bits, n,
                          instr_l, instr_r, timeout, exp_l(), exp_r(), m_timeout());
      end
    end
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_bad_header();
    test_bit_count();
    test_zero_field();
    test_watchdog();
    test_reset_mid_frame();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
